// File: rtl/uart_tx_fifo_if.sv
// Write-side port bundle for uart_tx_fifo: ready/valid byte push plus FIFO level.
interface uart_tx_fifo_if #(
   parameter int FIFO_DEPTH_LOG2 = 4
);
   logic                     send_req;
   logic [7:0]               send_data;
   logic                     send_ready;
   logic [FIFO_DEPTH_LOG2:0] fifo_level;

   // Producer side (I/O decoder or bench).
   modport master (
      output send_req,
      output send_data,
      input  send_ready,
      input  fifo_level
   );

   // Transmitter side.
   modport slave (
      input  send_req,
      input  send_data,
      output send_ready,
      output fifo_level
   );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes queue in a FIFO and are serialised on uart_tx
// with configurable baud divider, data width, parity and stop bits.
module uart_tx_fifo #(
   parameter int CLKS_PER_BIT    = 234,
   parameter int DATA_BITS       = 8,
   parameter int PARITY_MODE     = 0,
   parameter int STOP_BITS       = 1,
   parameter int FIFO_DEPTH_LOG2 = 4
) (
   input  logic          clk,
   input  logic          reset,
   uart_tx_fifo_if.slave wr,
   output logic          busy,
   output logic          uart_tx
);

   localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
   localparam int LW    = FIFO_DEPTH_LOG2 + 1;
   localparam logic [LW-1:0]              FULL_LEVEL = LW'(DEPTH);
   localparam logic [LW-1:0]              LEVEL_ONE  = 1;
   localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = 1;
   localparam logic [15:0]                LAST_TICK  = 16'(CLKS_PER_BIT - 1);
   localparam logic [2:0]                 LAST_DATA  = 3'(DATA_BITS - 1);
   localparam logic [2:0]                 LAST_STOP  = 3'(STOP_BITS - 1);
   localparam logic [7:0]                 DATA_MASK  = 8'((1 << DATA_BITS) - 1);
   localparam logic                       PARITY_ODD = (PARITY_MODE == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                     state_q, state_d;
   logic [15:0]                timer_q, timer_d;
   logic [2:0]                 bit_idx_q, bit_idx_d;
   logic [7:0]                 shift_q, shift_d;
   logic                       parity_q, parity_d;
   logic                       tx_q, tx_d;
   logic                       busy_q, busy_d;
   logic [LW-1:0]              level_q, level_d;
   logic                       ready_q, ready_d;
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [7:0]                 mem_q [DEPTH];

   logic       push;
   logic       pop;
   logic       empty;
   logic       cell_end;
   logic [7:0] head;

   assign push     = wr.send_req && ready_q;
   assign empty    = (level_q == '0);
   assign cell_end = (timer_q == LAST_TICK);
   assign head     = mem_q[rd_ptr_q];

   assign wr.send_ready = ready_q;
   assign wr.fifo_level = level_q;
   assign busy          = busy_q;
   assign uart_tx       = tx_q;

   // Frame sequencer: bit timer, state transitions, pop decision and line level.
   // The line level is derived from the current state, so uart_tx trails the
   // state register by one cycle; every cell still lasts CLKS_PER_BIT cycles.
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      busy_d    = busy_q;
      pop       = 1'b0;
      tx_d      = 1'b1;

      if (state_q != S_IDLE) begin
         timer_d = cell_end ? '0 : timer_q + 16'd1;
      end

      case (state_q)
         S_IDLE: begin
            timer_d = '0;
            if (!empty) begin
               pop     = 1'b1;
               state_d = S_START;
               busy_d  = 1'b1;
            end
         end
         S_START: begin
            tx_d = 1'b0;
            if (cell_end) begin
               state_d   = S_DATA;
               bit_idx_d = '0;
            end
         end
         S_DATA: begin
            tx_d = shift_q[bit_idx_q];
            if (cell_end) begin
               if (bit_idx_q == LAST_DATA) begin
                  bit_idx_d = '0;
                  state_d   = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         S_PARITY: begin
            tx_d = parity_q;
            if (cell_end) begin
               state_d   = S_STOP;
               bit_idx_d = '0;
            end
         end
         S_STOP: begin
            if (cell_end) begin
               if (bit_idx_q == LAST_STOP) begin
                  if (!empty) begin
                     pop     = 1'b1;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                     busy_d  = 1'b0;
                  end
               end else begin
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      if (pop) begin
         shift_d   = head;
         parity_d  = (^head) ^ PARITY_ODD;
         bit_idx_d = '0;
      end
   end

   // FIFO bookkeeping: pointers, level and registered not-full flag.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LEVEL_ONE;
         2'b01:   level_d = level_q - LEVEL_ONE;
         default: level_d = level_q;
      endcase
      ready_d = (level_d != FULL_LEVEL);
   end

   // State and control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         timer_q   <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         parity_q  <= 1'b0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         level_q   <= '0;
         ready_q   <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         parity_q  <= parity_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         level_q   <= level_d;
         ready_q   <= ready_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
      end
   end

   // FIFO storage; bits above DATA_BITS are cleared on entry so parity and
   // shifting never see them.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= wr.send_data & DATA_MASK;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: five instances cover 8N1, even/odd
// parity, 7-bit data and two stop bits; a byte scoreboard feeds a line decoder.
module tb_uart_tx_fifo;

   localparam int CPB = 4;
   localparam int N   = 5;
   localparam int DB [N] = '{8, 8, 8, 7, 8};
   localparam int PM [N] = '{0, 1, 2, 1, 0};
   localparam int SB [N] = '{1, 1, 1, 1, 2};

   logic         clk = 1'b0;
   logic         reset;
   logic         req [N];
   logic [7:0]   dat [N];
   logic [N-1:0] ready_v;
   logic [N-1:0] busy_v;
   logic [N-1:0] tx_v;
   logic [2:0]   level_v [N];

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] sb [$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      uart_tx_fifo_if #(.FIFO_DEPTH_LOG2(2)) wif ();
      uart_tx_fifo #(
         .CLKS_PER_BIT    (CPB),
         .DATA_BITS       (DB[g]),
         .PARITY_MODE     (PM[g]),
         .STOP_BITS       (SB[g]),
         .FIFO_DEPTH_LOG2 (2)
      ) u_dut (
         .clk     (clk),
         .reset   (reset),
         .wr      (wif),
         .busy    (busy_v[g]),
         .uart_tx (tx_v[g])
      );
      assign wif.send_req  = req[g];
      assign wif.send_data = dat[g];
      assign ready_v[g]    = wif.send_ready;
      assign level_v[g]    = wif.fifo_level;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at a negedge; drives one write across the next posedge.
   task automatic write_byte(input int idx, input logic [7:0] d, input logic exp_acc, input string tag);
      check_eq({tag, ".ready"}, 32'(ready_v[idx]), 32'(exp_acc));
      req[idx] = 1'b1;
      dat[idx] = d;
      if (exp_acc) sb.push_back(d);
      @(negedge clk);
      req[idx] = 1'b0;
   endtask

   // Waits for a start bit, then checks every cell of one frame sample by sample.
   task automatic frame_check(input int idx, input int exp_gap, input string tag);
      int         gap;
      int         n;
      logic [7:0] d;
      logic [7:0] m;
      logic       cells [12];
      logic [CPB-1:0] s;
      gap = 0;
      @(negedge clk);
      while (tx_v[idx] !== 1'b0 && gap < 400) begin
         gap++;
         @(negedge clk);
      end
      check_eq({tag, ".start_seen"}, 32'(tx_v[idx]), 32'd0);
      if (tx_v[idx] !== 1'b0) return;
      if (exp_gap >= 0) check_eq({tag, ".gap"}, gap, exp_gap);
      check_eq({tag, ".sb_has_entry"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() == 0) return;
      d = sb.pop_front();
      m = 8'((1 << DB[idx]) - 1);
      d = d & m;
      cells[0] = 1'b0;
      n = 1;
      for (int b = 0; b < DB[idx]; b++) begin
         cells[n] = d[b];
         n++;
      end
      if (PM[idx] != 0) begin
         cells[n] = (^d) ^ (PM[idx] == 2);
         n++;
      end
      for (int k = 0; k < SB[idx]; k++) begin
         cells[n] = 1'b1;
         n++;
      end
      for (int c = 0; c < n; c++) begin
         for (int j = 0; j < CPB; j++) begin
            if (!(c == 0 && j == 0)) @(negedge clk);
            s[j] = tx_v[idx];
         end
         check_eq($sformatf("%s.cell%0d", tag, c), 32'(s), 32'({CPB{cells[c]}}));
      end
   endtask

   // Line must stay idle and busy low for a number of cycles.
   task automatic quiet_check(input int idx, input int cycles, input string tag);
      int lows;
      int busys;
      lows  = 0;
      busys = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (tx_v[idx] !== 1'b1) lows++;
         if (busy_v[idx] !== 1'b0) busys++;
      end
      check_eq({tag, ".line_low_cycles"}, lows, 0);
      check_eq({tag, ".busy_cycles"}, busys, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      for (int i = 0; i < N; i++) begin
         req[i] = 1'b0;
         dat[i] = 8'h00;
      end

      // Reset values held throughout reset.
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         check_eq("rst.tx", 32'(tx_v[0]), 32'd1);
         check_eq("rst.busy", 32'(busy_v[0]), 32'd0);
         check_eq("rst.ready", 32'(ready_v[0]), 32'd1);
         check_eq("rst.level", 32'(level_v[0]), 32'd0);
         @(negedge clk);
      end
      // Writes during reset are not queued.
      req[0] = 1'b1;
      dat[0] = 8'hAA;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("rst_req.level", 32'(level_v[0]), 32'd0);
         check_eq("rst_req.ready", 32'(ready_v[0]), 32'd1);
      end
      reset  = 1'b0;
      req[0] = 1'b0;
      @(negedge clk);
      check_eq("rst_rel.level", 32'(level_v[0]), 32'd0);
      quiet_check(0, 20, "rst_rel");

      // Single 8N1 frame with write-to-line latency and busy length.
      write_byte(0, 8'h55, 1'b1, "single");
      check_eq("single.level_after_write", 32'(level_v[0]), 32'd1);
      check_eq("single.busy_after_write", 32'(busy_v[0]), 32'd0);
      fork
         begin : busy_meter
            int cnt;
            @(negedge clk);
            check_eq("single.level_after_pop", 32'(level_v[0]), 32'd0);
            cnt = 0;
            while (busy_v[0] && cnt < 200) begin
               cnt++;
               @(negedge clk);
            end
            check_eq("single.busy_len", cnt, 40);
         end
         frame_check(0, 1, "single");
      join

      // FIFO full: 0x06 is dropped, 0x01..0x05 sent back-to-back.
      fork
         begin
            for (int k = 1; k <= 6; k++) begin
               write_byte(0, 8'(k), (k <= 5), $sformatf("fifo.wr%0d", k));
            end
            check_eq("fifo.level_full", 32'(level_v[0]), 32'd4);
            check_eq("fifo.ready_full", 32'(ready_v[0]), 32'd0);
            check_eq("fifo.busy", 32'(busy_v[0]), 32'd1);
         end
         begin
            for (int k = 0; k < 5; k++) begin
               frame_check(0, (k == 0) ? -1 : 0, $sformatf("fifo.f%0d", k));
            end
         end
      join
      quiet_check(0, 30, "fifo_after");
      check_eq("fifo.level_end", 32'(level_v[0]), 32'd0);

      // Parity: even 0x03 -> 0, odd 0x03 -> 1, 7-bit even 0x80 -> data 0, parity 0.
      write_byte(1, 8'h03, 1'b1, "par_even");
      frame_check(1, 1, "par_even");
      write_byte(2, 8'h03, 1'b1, "par_odd");
      frame_check(2, 1, "par_odd");
      write_byte(3, 8'h80, 1'b1, "par_7bit");
      frame_check(3, 1, "par_7bit");

      // Two stop bits between back-to-back frames, no extra gap.
      write_byte(4, 8'hFF, 1'b1, "stop2_a");
      write_byte(4, 8'h00, 1'b1, "stop2_b");
      frame_check(4, -1, "stop2_a");
      frame_check(4, 0, "stop2_b");
      quiet_check(4, 10, "stop2_after");

      // Mid-frame reset during the third data bit.
      write_byte(0, 8'hA5, 1'b1, "midrst_a");
      write_byte(0, 8'h5A, 1'b1, "midrst_b");
      begin : wait_start
         int w;
         w = 0;
         while (tx_v[0] !== 1'b0 && w < 50) begin
            w++;
            @(negedge clk);
         end
      end
      check_eq("midrst.start_seen", 32'(tx_v[0]), 32'd0);
      repeat (4 + 8 + 1) @(negedge clk);
      check_eq("midrst.bit2", 32'(tx_v[0]), 32'd1);
      check_eq("midrst.level_before", 32'(level_v[0]), 32'd1);
      check_eq("midrst.busy_before", 32'(busy_v[0]), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check_eq("midrst.tx", 32'(tx_v[0]), 32'd1);
      check_eq("midrst.level", 32'(level_v[0]), 32'd0);
      check_eq("midrst.busy", 32'(busy_v[0]), 32'd0);
      check_eq("midrst.ready", 32'(ready_v[0]), 32'd1);
      reset = 1'b0;
      sb.delete();
      quiet_check(0, 60, "midrst_after");

      check_eq("sb.empty_end", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
